// File: rtl/fp_mac_pkg.sv
// Shared types and default constants for the FP MAC sequencer.
// Optional stall counter is enabled by defining FP_MAC_CTRL_PERF_EN.
package fp_mac_pkg;

  // Controller phases: idle, element streaming, result presented.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MUL_LAT_DEF = 2;
  localparam int unsigned ADD_LAT_DEF = 3;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned STALL_W     = 16;

endpackage : fp_mac_pkg

// File: rtl/fp_mac_if.sv
// Job, operand handshake and datapath-enable bundle between the sequencer and its neighbours.
interface fp_mac_if
  import fp_mac_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             mul_en;
  logic             add_en;
  logic             add_sel_acc;
  logic             acc_clr;
  logic             acc_we;
  logic             busy;
  logic             out_valid;
  logic             out_ready;

  // Sequencer side: drives the enables and the handshakes it owns.
  modport master (
    input  start, len, in_valid, out_ready,
    output in_ready, mul_en, add_en, add_sel_acc, acc_clr, acc_we, busy, out_valid
  );

  // Environment side: job source, operand source, result sink and datapath.
  modport slave (
    output start, len, in_valid, out_ready,
    input  in_ready, mul_en, add_en, add_sel_acc, acc_clr, acc_we, busy, out_valid
  );

endinterface : fp_mac_if

// File: rtl/fp_mac_valid_pipe.sv
// Resettable valid shift register with an optional side tag travelling alongside each valid.
module fp_mac_valid_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 1,
  localparam int unsigned TW   = (W == 0) ? 1 : W
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          valid_i,
  input  logic [TW-1:0] tag_i,
  output logic          valid_o,
  output logic [TW-1:0] tag_o
);

  logic [DEPTH-1:0] vld_q;

  // Shift the valid bits one stage per cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];

  if (W == 0) begin : g_notag
    logic unused_tag;
    assign unused_tag = ^tag_i;
    assign tag_o      = '0;
  end else begin : g_tag
    logic [TW-1:0] tag_q [DEPTH];

    // Tags follow the same shift as the valids.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          tag_q[i] <= '0;
        end
      end else begin
        tag_q[0] <= tag_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
          tag_q[i] <= tag_q[i-1];
        end
      end
    end

    assign tag_o = tag_q[DEPTH-1];
  end

endmodule : fp_mac_valid_pipe

// File: rtl/fp_mac_ctrl.sv
// Sequencer for the FP MAC datapath: admits operand pairs spaced ADD_LAT apart so every
// accumulate add sees the previous sum, then presents one result per job.
// Optional stall_cnt port and counter: define FP_MAC_CTRL_PERF_EN.
module fp_mac_ctrl
  import fp_mac_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned ADD_LAT = ADD_LAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  fp_mac_if.master           bus
`ifdef FP_MAC_CTRL_PERF_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  localparam int unsigned GAP_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ADD_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             first_q, first_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  logic             job_start_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             last_res_c;
  logic             add_en;
  logic             first_tag;
  logic             acc_we;
  logic [0:0]       add_tag_unused;

  // Multiplier latency: carries each accept plus whether it is the job's first element.
  fp_mac_valid_pipe #(
    .DEPTH (MUL_LAT),
    .W     (1)
  ) u_mul_pipe (
    .clock   (clock),
    .resetn  (resetn),
    .valid_i (accept_c),
    .tag_i   (first_q),
    .valid_o (add_en),
    .tag_o   (first_tag)
  );

  // Adder latency (pre-stage included): its output is the accumulator write.
  fp_mac_valid_pipe #(
    .DEPTH (ADD_LAT),
    .W     (0)
  ) u_add_pipe (
    .clock   (clock),
    .resetn  (resetn),
    .valid_i (add_en),
    .tag_i   (1'b0),
    .valid_o (acc_we),
    .tag_o   (add_tag_unused)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Final element lands this cycle: leave RUN so out_valid shows up the cycle after.
  assign last_res_c = acc_we & ((res_cnt_q + CNT_ONE) == len_q);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = (bus.len == '0) ? DONE : RUN;
      RUN:  if (last_res_c) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: admission window, accept strobe, clear pulse and next registered flags.
  always_comb begin
    job_start_c = 1'b0;
    in_ready_c  = 1'b0;
    accept_c    = 1'b0;
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    if (state_q == IDLE) begin
      job_start_c = bus.start;
    end
    if (state_q == RUN) begin
      in_ready_c = (iss_cnt_q != '0) && (gap_cnt_q == '0);
    end
    accept_c = in_ready_c & bus.in_valid;
  end

  // Job bookkeeping: remaining issues, completed results and admission spacing.
  always_comb begin
    len_d     = len_q;
    iss_cnt_d = iss_cnt_q;
    res_cnt_d = res_cnt_q;
    gap_cnt_d = gap_cnt_q;
    first_d   = first_q;
    if (job_start_c) begin
      len_d     = bus.len;
      iss_cnt_d = bus.len;
      res_cnt_d = '0;
      gap_cnt_d = '0;
      first_d   = 1'b1;
    end else begin
      if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_ONE;
      if (accept_c) begin
        iss_cnt_d = iss_cnt_q - CNT_ONE;
        gap_cnt_d = GAP_LOAD;
        first_d   = 1'b0;
      end
      if (acc_we) res_cnt_d = res_cnt_q + CNT_ONE;
    end
  end

  // Counter and registered-output flops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      len_q       <= '0;
      iss_cnt_q   <= '0;
      res_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      len_q       <= len_d;
      iss_cnt_q   <= iss_cnt_d;
      res_cnt_q   <= res_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      first_q     <= first_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.mul_en      = accept_c;
  assign bus.add_en      = add_en;
  assign bus.add_sel_acc = add_en & ~first_tag;
  assign bus.acc_clr     = job_start_c;
  assign bus.acc_we      = acc_we;
  assign bus.busy        = busy_q;
  assign bus.out_valid   = out_valid_q;

`ifdef FP_MAC_CTRL_PERF_EN
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Stall = upstream offers data for a still-owed element but spacing holds it off.
  always_comb begin
    stall_d = stall_q;
    if (job_start_c) begin
      stall_d = '0;
    end else if ((state_q == RUN) && bus.in_valid && !in_ready_c &&
                 (iss_cnt_q != '0) && (stall_q != '1)) begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  // Saturating stall counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule : fp_mac_ctrl

// File: tb/tb_fp_mac_ctrl.sv
// Self-checking bench for fp_mac_ctrl (MUL_LAT=2, ADD_LAT=3, CNT_W=8).
module tb_fp_mac_ctrl;

  localparam int MUL_LAT = 2;
  localparam int ADD_LAT = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  fp_mac_if #(.CNT_W(8)) bus ();

`ifdef FP_MAC_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  fp_mac_ctrl #(
    .MUL_LAT (MUL_LAT),
    .ADD_LAT (ADD_LAT),
    .CNT_W   (8)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
`ifdef FP_MAC_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Output snapshot: {in_ready, mul_en, add_en, add_sel_acc, acc_clr, acc_we, busy, out_valid}
  function automatic logic [7:0] outs();
    return {bus.in_ready, bus.mul_en, bus.add_en, bus.add_sel_acc,
            bus.acc_clr, bus.acc_we, bus.busy, bus.out_valid};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one job from the start pulse to the idle cycle after out_ready, checking every cycle.
  // vmode 0: in_valid always 1; 1: 1,0,0,0,0 repeating; 2: random.
  task automatic run_job(input int n, input int vmode, input int ordly,
                         output int ov_cyc, output int n_mul, output int n_we);
    int          acc_cyc[$];
    int          rem, wes, t, stalls;
    bit          v, rdy, acc, ae, sel, we;
    logic [7:0]  exp;
    ov_cyc = -1; n_mul = 0; n_we = 0;
    bus.start = 1'b1; bus.len = 8'(n); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    total++;
    if (outs() !== 8'h08) begin
      bad++;
      $display("FAIL job_start n=%0d got=%b exp=%b", n, outs(), 8'h08);
    end
    tick();
    bus.start = 1'b0;
    t = 1; rem = n; wes = 0; stalls = 0;
    while (wes < n && t < 4000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ((t - 1) % 5) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      #1;
      rdy = (rem > 0) && (acc_cyc.size() == 0 || (t - acc_cyc[$]) >= ADD_LAT);
      acc = rdy && v;
      ae = 0; sel = 0; we = 0;
      foreach (acc_cyc[k]) begin
        if (acc_cyc[k] + MUL_LAT == t) begin ae = 1; sel = (k != 0); end
        if (acc_cyc[k] + MUL_LAT + ADD_LAT == t) we = 1;
      end
      exp = {rdy, acc, ae, sel, 1'b0, we, 1'b1, 1'b0};
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL run_cycle n=%0d t=%0d got=%b exp=%b", n, t, outs(), exp);
      end
      if (bus.mul_en === 1'b1) n_mul++;
      if (bus.acc_we === 1'b1) n_we++;
      if (v && !rdy && rem > 0) stalls++;
      if (acc) begin acc_cyc.push_back(t); rem--; end
      if (we) wes++;
      tick();
      t++;
    end
    if (wes < n) begin
      total++; bad++;
      $display("FAIL job_timeout n=%0d results=%0d", n, wes);
    end
    for (int i = 0; i < ordly; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.len = 8'($urandom_range(0, 255));
      bus.in_valid = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid === 1'b1 && ov_cyc < 0) ov_cyc = t;
      total++;
      if (outs() !== 8'h03) begin
        bad++;
        $display("FAIL done_hold n=%0d t=%0d got=%b exp=%b", n, t, outs(), 8'h03);
      end
      tick();
      t++;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    if (bus.out_valid === 1'b1 && ov_cyc < 0) ov_cyc = t;
    total++;
    if (outs() !== 8'h03) begin
      bad++;
      $display("FAIL done_take n=%0d t=%0d got=%b exp=%b", n, t, outs(), 8'h03);
    end
`ifdef FP_MAC_CTRL_PERF_EN
    total++;
    if (stall_cnt !== 16'(stalls)) begin
      bad++;
      $display("FAIL stall_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, stalls);
    end
`endif
    tick();
    bus.out_ready = 1'b0;
    #1;
    total++;
    if (outs() !== 8'h00) begin
      bad++;
      $display("FAIL idle_after n=%0d got=%b exp=%b", n, outs(), 8'h00);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    total++;
    if (outs() !== 8'h00) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=%b", outs(), 8'h00);
    end
    resetn = 1'b1;
    tick();
  endtask

  // len=4, constant in_valid: accepts 1,4,7,10; acc_we 6,9,12,15; out_valid at 16.
  task automatic test_single_job();
    int ov, nm, nw;
    run_job(4, 0, 0, ov, nm, nw);
    total++;
    if (ov !== 16) begin bad++; $display("FAIL t1_out_valid_cycle got=%0d exp=16", ov); end
    total++;
    if (nm !== 4 || nw !== 4) begin
      bad++; $display("FAIL t1_counts mul=%0d we=%0d exp=4/4", nm, nw);
    end
    tick();
  endtask

  task automatic test_zero_len();
    int ov, nm, nw;
    run_job(0, 0, 5, ov, nm, nw);
    total++;
    if (ov !== 1) begin bad++; $display("FAIL t3_out_valid_cycle got=%0d exp=1", ov); end
    tick();
  endtask

  task automatic test_sparse_valid();
    int ov, nm, nw;
    run_job(3, 1, 1, ov, nm, nw);
    total++;
    if (nm !== 3 || nw !== 3) begin
      bad++; $display("FAIL t4_counts mul=%0d we=%0d exp=3/3", nm, nw);
    end
    tick();
  endtask

  // Reset two cycles after the 2nd accept of a len=5 job, then a fresh len=1 job.
  task automatic test_reset_mid();
    int nm, ov, nw;
    nm = 0;
    bus.start = 1'b1; bus.len = 8'd5; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      #1;
      if (bus.mul_en === 1'b1) nm++;
      tick();
    end
    total++;
    if (nm !== 2) begin bad++; $display("FAIL t5_pre_reset_accepts got=%0d exp=2", nm); end
    resetn = 1'b0;
    #1;
    total++;
    if (outs() !== 8'h00) begin bad++; $display("FAIL t5_in_reset got=%b exp=%b", outs(), 8'h00); end
    tick(); tick();
    resetn = 1'b1;
    for (int t = 0; t < 12; t++) begin
      #1;
      total++;
      if (outs() !== 8'h00) begin
        bad++; $display("FAIL t5_after_reset t=%0d got=%b exp=%b", t, outs(), 8'h00);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    run_job(1, 0, 0, ov, nm, nw);
    total++;
    if (nm !== 1 || nw !== 1) begin
      bad++; $display("FAIL t5_new_job mul=%0d we=%0d exp=1/1", nm, nw);
    end
    tick();
  endtask

  task automatic test_random();
    int ov, nm, nw, n;
    for (int j = 0; j < 10; j++) begin
      n = $urandom_range(1, 15);
      run_job(n, 2, $urandom_range(0, 3), ov, nm, nw);
      total++;
      if (nm !== n || nw !== n) begin
        bad++; $display("FAIL rand_counts n=%0d mul=%0d we=%0d", n, nm, nw);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_long_job();
    int ov, nm, nw;
    run_job(255, 0, 2, ov, nm, nw);
    total++;
    if (nm !== 255 || nw !== 255) begin
      bad++; $display("FAIL long_counts mul=%0d we=%0d exp=255/255", nm, nw);
    end
    total++;
    if (ov !== 3 * 254 + 1 + MUL_LAT + ADD_LAT + 1) begin
      bad++; $display("FAIL long_out_valid_cycle got=%0d exp=%0d", ov, 3 * 254 + 1 + MUL_LAT + ADD_LAT + 1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_zero_len();
    test_sparse_valid();
    test_reset_mid();
    test_random();
    test_long_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fp_mac_ctrl
